// File: rtl/param_heap.sv
// param_heap: parameterised binary min/max heap with a one-level-per-cycle
// sift engine. Entries live in a flat array; children of entry i sit at
// 2i+1 and 2i+2. MAX_HEAP selects max-heap ordering.
// Optional feature: define PARAM_HEAP_ERR_EN to add a sticky err output that
// flags ignored push-when-full / pop-when-empty commands.
module param_heap #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int MAX_HEAP = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         data_in,
`ifdef PARAM_HEAP_ERR_EN
    output logic                      err,
`endif
    output logic                      ready,
    output logic [DATA_W-1:0]         data_out,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         peek,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // One spare bit above the count width so 2*idx+2 cannot wrap.
    localparam int IW = AW + 2;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [AW-1:0] ADR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SIFT_UP   = 2'd1,
        SIFT_DOWN = 2'd2
    } state_t;

    // a ranks strictly ahead of b; equal keys never reorder
    function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (MAX_HEAP != 0) begin
            better = (a > b);
        end else begin
            better = (a < b);
        end
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    state_t            state_r, state_nx_s;
    logic [IW-1:0]     idx_r, idx_nx_s;
    logic [CW-1:0]     count_r, count_nx_s;
    logic              empty_r, full_r, ready_r, out_valid_r;
    logic [DATA_W-1:0] data_out_r;

    logic              wr_a_en_s, wr_b_en_s, out_ld_s, err_set_s;
    logic [AW-1:0]     wr_a_addr_s, wr_b_addr_s;
    logic [DATA_W-1:0] wr_a_data_s, wr_b_data_s;

    logic [IW-1:0]     parent_s, left_s, right_s, lbest_s, best_s;
    logic [IW-1:0]     count_ext_s;
    logic [AW-1:0]     last_adr_s;
    logic [DATA_W-1:0] cur_s, par_val_s, left_val_s, right_val_s, last_val_s;
    logic [DATA_W-1:0] lbest_val_s, best_val_s;
    logic              left_ok_s, right_ok_s;

    assign count_ext_s = {1'b0, count_r};
    assign parent_s    = (idx_r - IDX_ONE) >> 1'b1;
    assign left_s      = {idx_r[IW-2:0], 1'b0} + IDX_ONE;
    assign right_s     = left_s + IDX_ONE;
    assign last_adr_s  = count_r[AW-1:0] - ADR_ONE;

    assign cur_s       = mem_r[idx_r[AW-1:0]];
    assign par_val_s   = mem_r[parent_s[AW-1:0]];
    assign left_val_s  = mem_r[left_s[AW-1:0]];
    assign right_val_s = mem_r[right_s[AW-1:0]];
    assign last_val_s  = mem_r[last_adr_s];

    // Best of parent/left/right among live entries; left keeps ties.
    assign left_ok_s   = (left_s < count_ext_s) && better(left_val_s, cur_s);
    assign lbest_s     = left_ok_s ? left_s : idx_r;
    assign lbest_val_s = left_ok_s ? left_val_s : cur_s;
    assign right_ok_s  = (right_s < count_ext_s) && better(right_val_s, lbest_val_s);
    assign best_s      = right_ok_s ? right_s : lbest_s;
    assign best_val_s  = right_ok_s ? right_val_s : lbest_val_s;

    // Command decode and sift step: next state, index, count and array writes
    always_comb begin
        state_nx_s  = state_r;
        idx_nx_s    = idx_r;
        count_nx_s  = count_r;
        wr_a_en_s   = 1'b0;
        wr_a_addr_s = ADR_ZERO;
        wr_a_data_s = {DATA_W{1'b0}};
        wr_b_en_s   = 1'b0;
        wr_b_addr_s = ADR_ZERO;
        wr_b_data_s = {DATA_W{1'b0}};
        out_ld_s    = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (push && (!pop || empty_r) && !full_r) begin
                    // append at the tail, then bubble up
                    wr_a_en_s   = 1'b1;
                    wr_a_addr_s = count_r[AW-1:0];
                    wr_a_data_s = data_in;
                    count_nx_s  = count_r + CNT_ONE;
                    idx_nx_s    = {1'b0, count_r};
                    state_nx_s  = SIFT_UP;
                end else if (pop && !empty_r) begin
                    out_ld_s    = 1'b1;
                    wr_a_en_s   = 1'b1;
                    wr_a_addr_s = ADR_ZERO;
                    idx_nx_s    = IDX_ZERO;
                    if (push) begin
                        // replace: new key takes the root slot
                        wr_a_data_s = data_in;
                        state_nx_s  = SIFT_DOWN;
                    end else begin
                        wr_a_data_s = last_val_s;
                        count_nx_s  = count_r - CNT_ONE;
                        if (count_r <= CNT_TWO) begin
                            state_nx_s = IDLE;
                        end else begin
                            state_nx_s = SIFT_DOWN;
                        end
                    end
                end else begin
                    err_set_s = (push && !pop && full_r) || (pop && !push && empty_r);
                end
            end
            SIFT_UP: begin
                if ((idx_r != IDX_ZERO) && better(cur_s, par_val_s)) begin
                    wr_a_en_s   = 1'b1;
                    wr_a_addr_s = idx_r[AW-1:0];
                    wr_a_data_s = par_val_s;
                    wr_b_en_s   = 1'b1;
                    wr_b_addr_s = parent_s[AW-1:0];
                    wr_b_data_s = cur_s;
                    idx_nx_s    = parent_s;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SIFT_DOWN: begin
                if (best_s != idx_r) begin
                    wr_a_en_s   = 1'b1;
                    wr_a_addr_s = idx_r[AW-1:0];
                    wr_a_data_s = best_val_s;
                    wr_b_en_s   = 1'b1;
                    wr_b_addr_s = best_s[AW-1:0];
                    wr_b_data_s = cur_s;
                    idx_nx_s    = best_s;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Control registers; storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= IDX_ZERO;
            count_r     <= CNT_ZERO;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            ready_r     <= 1'b1;
            out_valid_r <= 1'b0;
            data_out_r  <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            idx_r       <= idx_nx_s;
            count_r     <= count_nx_s;
            empty_r     <= (count_nx_s == CNT_ZERO);
            full_r      <= (count_nx_s == CNT_FULL);
            ready_r     <= (state_nx_s == IDLE);
            out_valid_r <= out_ld_s;
            if (out_ld_s) begin
                data_out_r <= mem_r[0];
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    // Heap storage: up to two writes per cycle (a swap)
    always_ff @(posedge clk) begin
        if (wr_a_en_s) begin
            mem_r[wr_a_addr_s] <= wr_a_data_s;
        end
        if (wr_b_en_s) begin
            mem_r[wr_b_addr_s] <= wr_b_data_s;
        end
    end

`ifdef PARAM_HEAP_ERR_EN
    logic err_r;

    // Sticky flag for commands dropped because the heap was full/empty
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    logic unused_err_s;
    assign unused_err_s = err_set_s;
`endif

    assign ready     = ready_r;
    assign data_out  = data_out_r;
    assign out_valid = out_valid_r;
    assign peek      = mem_r[0];
    assign count     = count_r;
    assign empty     = empty_r;
    assign full      = full_r;

endmodule

// File: doc/param_heap.md
PARAM_HEAP -- requirements
Module: param_heap

Interface
REQ-001 Parameter DATA_W, default 8, key/data width in bits.
REQ-002 Parameter DEPTH, default 8, capacity in entries; power of two, 2..256.
REQ-003 Parameter MAX_HEAP, default 0, ordering: 0 = min-heap (smallest at root), 1 = max-heap (largest at root).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 push  input  1  insert data_in; sampled only when ready=1.
REQ-007 pop  input  1  remove root; sampled only when ready=1.
REQ-008 data_in  input  DATA_W  value to insert.
REQ-009 ready  output  1  block in IDLE and able to accept a command.
REQ-010 data_out  output  DATA_W  last removed root, registered; held until the next removal.
REQ-011 out_valid  output  1  one-cycle pulse when data_out updates.
REQ-012 peek  output  DATA_W  current root entry (combinational from storage); valid when empty=0 and ready=1.
REQ-013 count  output  log2(DEPTH)+1  number of stored entries.
REQ-014 empty, full  output  1 each  count==0, count==DEPTH respectively.

Function
REQ-015 FSM states: IDLE, SIFT_UP, SIFT_DOWN; ready=1 only in IDLE.
REQ-016 Ordering: "better" = strictly less (MAX_HEAP=0) or strictly greater (MAX_HEAP=1); equal keys never swap.
REQ-017 Push only (IDLE, push=1, pop=0, full=0): write data_in at index count, count+1, idx<=old count, enter SIFT_UP.
REQ-018 SIFT_UP, one level per cycle: if idx>0 and entry[idx] better than entry[(idx-1)/2], swap and idx<=parent; otherwise return to IDLE.
REQ-019 Pop only (IDLE, pop=1, push=0, empty=0): data_out<=root, out_valid=1 next cycle, root<=entry[count-1], count-1; if new count<=1 return directly to IDLE, else idx<=0 and enter SIFT_DOWN.
REQ-020 SIFT_DOWN, one level per cycle: pick best of idx, 2idx+1, 2idx+2 considering only indices < count, left child wins ties; if best!=idx swap and idx<=best, else return to IDLE.
REQ-021 Replace (IDLE, push=1, pop=1, empty=0): data_out<=root, out_valid pulse, root<=data_in, count unchanged, enter SIFT_DOWN; allowed when full.
REQ-022 Push+pop when empty: treated as push only; out_valid stays 0.
REQ-023 Push when full (pop=0) and pop when empty are ignored: no state, count or data_out change.
REQ-024 push/pop while ready=0 are ignored; the requester holds them until ready=1.
REQ-025 Latency: push/replace/pop return to IDLE within log2(DEPTH)+1 cycles of acceptance.
REQ-026 count, empty and full update in the cycle after acceptance and do not change during SIFT states.
REQ-027 Index arithmetic is sized so that 2idx+2 never wraps at DEPTH=256.

Reset
REQ-028 rst=1 at a clock edge: state=IDLE, count=0, empty=1, full=0, out_valid=0, data_out=0, idx=0; storage contents are not cleared.
REQ-029 rst asserted mid-SIFT aborts the operation; the heap is empty on the following cycle.

Configuration
REQ-030 Macro PARAM_HEAP_ERR_EN defined: adds output err (1 bit), sticky, set on an ignored push-when-full or pop-when-empty, cleared only by rst.
REQ-031 Macro PARAM_HEAP_ERR_EN undefined: no err port, no error logic; REQ-023 behaviour is unchanged.

Verification (DATA_W=8, DEPTH=8)
REQ-032 Push 5,3,8,1 and wait for ready after each -> peek=1, count=4; four pops -> data_out 1,3,5,8, each with one out_valid pulse, empty=1.
REQ-033 MAX_HEAP=1: push 5,3,8,1 then pop x4 -> data_out 8,5,3,1.
REQ-034 Push 8 values 80,70..10 -> full=1; push 5 -> ignored, count=8 (err=1 when PARAM_HEAP_ERR_EN is defined); pop -> data_out=10, full=0.
REQ-035 Heap {2,4,6}, replace with data_in=5 -> data_out=2, count=3, peek=4; pops yield 4,5,6.
REQ-036 Push 1 then pop on an empty heap -> data_out=1; second pop ignored, out_valid=0; simultaneous push+pop on empty with 7 -> count=1, no out_valid.
REQ-037 Push 9,8,7, assert rst during SIFT_UP -> next cycle count=0, empty=1, ready=1; push 4 then pop -> data_out=4.
